// File: rtl/memory_slave.sv
// memory_slave: single-port word memory behind a valid/taken request channel,
// with in-order read responses returned on a valid/taken response channel.
//
// Ports
//   clock      rising-edge clock for all state
//   reset      synchronous, active-high reset
//   msValid    request present            msTaken    request accepted this cycle
//   msAddress  word address of request     msData     write data
//   msID       request tag                 msWrite    1 = write, 0 = read
//   smValid    read response present       smTaken    response accepted this cycle
//   smData     read data (0 when idle)     smID       tag of the originating read
//
// Read pipeline: accept (memory read into rd_q) -> in-flight stage -> 2-entry
// response FIFO whose head drives smData/smID directly.
module memory_slave #(
    parameter int unsigned DEPTH = 1024,
    parameter logic [31:0] BASE  = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        msValid,
    output logic        msTaken,
    input  logic [31:0] msAddress,
    input  logic [31:0] msData,
    input  logic [7:0]  msID,
    input  logic        msWrite,
    output logic        smValid,
    input  logic        smTaken,
    output logic [31:0] smData,
    output logic [7:0]  smID
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  id;
    } entry_t;

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] idx_c;
    logic          in_range_c;
    logic          accept_c;
    logic          wr_c;
    logic          rd_c;
    logic          pop_c;
    logic [2:0]    occ_c;

    entry_t     rd_q;
    logic [1:0] count_q, count_d;
    logic       inflight_q, inflight_d;
    logic       init_q;
    entry_t     slot0_q, slot0_d;
    entry_t     slot1_q, slot1_d;

    // BASE is DEPTH-aligned, so the index is just the low address bits.
    assign idx_c      = msAddress[AW-1:0];
    assign in_range_c = (msAddress[31:AW] == BASE[31:AW]);

    // Occupancy after this cycle's pop; a pop frees a slot on the same edge,
    // which keeps a one-read-per-cycle stream flowing.
    assign pop_c   = smValid && smTaken;
    assign occ_c   = 3'(count_q) + 3'(inflight_q) - 3'(pop_c);
    assign msTaken = init_q && (occ_c < 3'd2);

    assign accept_c = msValid && msTaken && !reset;
    assign wr_c     = accept_c && msWrite;
    assign rd_c     = accept_c && !msWrite;

    // Head slot is kept zero while empty, so the outputs need no masking.
    assign smValid = (count_q != 2'd0);
    assign smData  = slot0_q.data;
    assign smID    = slot0_q.id;

    // Memory array and its read register; contents are never reset.
    always_ff @(posedge clock) begin
        if (wr_c && in_range_c) begin
            mem[idx_c] <= msData;
        end
        if (rd_c) begin
            rd_q.data <= in_range_c ? mem[idx_c] : 32'h0;
            rd_q.id   <= msID;
        end
    end

    // Pipeline and FIFO state.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            init_q     <= 1'b0;
            slot0_q    <= '0;
            slot1_q    <= '0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            init_q     <= 1'b1;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
        end
    end

    // Next-state for the in-flight stage and the shifting response FIFO.
    always_comb begin
        inflight_d = rd_c;
        count_d    = count_q + 2'(inflight_q) - 2'(pop_c);
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;
        if (pop_c) begin
            if (count_q == 2'd2) begin
                slot0_d = slot1_q;
                slot1_d = inflight_q ? rd_q : '0;
            end else begin
                slot0_d = inflight_q ? rd_q : '0;
                slot1_d = '0;
            end
        end else if (inflight_q) begin
            if (count_q == 2'd0) begin
                slot0_d = rd_q;
            end else begin
                slot1_d = rd_q;
            end
        end
    end

endmodule

// File: tb/tb_memory_slave.sv
// Self-checking bench for memory_slave: instance A (BASE=0) and instance B
// (BASE=0x400), both DEPTH=1024. Reads push expected {data,id} into a queue
// per instance; a negedge monitor pops and compares on each response transfer.
module tb_memory_slave;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  id;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             reset;
    logic [1:0]       ms_valid, ms_taken, ms_write, sm_valid, sm_taken;
    logic [1:0][31:0] ms_addr, ms_data, sm_data;
    logic [1:0][7:0]  ms_id, sm_id;

    int tests = 0;
    int fails = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] model0 [int];
    logic [31:0] model1 [int];

    memory_slave #(.DEPTH(1024), .BASE(32'h0)) u_a (
        .clock(clock), .reset(reset),
        .msValid(ms_valid[0]), .msTaken(ms_taken[0]), .msAddress(ms_addr[0]),
        .msData(ms_data[0]), .msID(ms_id[0]), .msWrite(ms_write[0]),
        .smValid(sm_valid[0]), .smTaken(sm_taken[0]), .smData(sm_data[0]),
        .smID(sm_id[0])
    );

    memory_slave #(.DEPTH(1024), .BASE(32'h400)) u_b (
        .clock(clock), .reset(reset),
        .msValid(ms_valid[1]), .msTaken(ms_taken[1]), .msAddress(ms_addr[1]),
        .msData(ms_data[1]), .msID(ms_id[1]), .msWrite(ms_write[1]),
        .smValid(sm_valid[1]), .smTaken(sm_taken[1]), .smData(sm_data[1]),
        .smID(sm_id[1])
    );

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input int k, input logic [31:0] a);
        return (k == 0) ? (a[31:10] == 22'd0) : (a[31:10] == 22'd1);
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive one request and hold it until accepted or max_wait cycles pass.
    task automatic issue(input int k, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [7:0] id,
                         input int max_wait, output bit ok);
        exp_t e;
        ms_valid[k] = 1'b1;
        ms_write[k] = wr;
        ms_addr[k]  = a;
        ms_data[k]  = d;
        ms_id[k]    = id;
        ok = 1'b0;
        for (int i = 0; i < max_wait && !ok; i++) begin
            @(negedge clock);
            if (ms_taken[k] === 1'b1) begin
                ok = 1'b1;
                if (wr) begin
                    if (in_rng(k, a)) begin
                        if (k == 0) model0[int'(a[9:0])] = d;
                        else        model1[int'(a[9:0])] = d;
                    end
                end else begin
                    e.id = id;
                    if (!in_rng(k, a))  e.data = 32'h0;
                    else if (k == 0)    e.data = model0[int'(a[9:0])];
                    else                e.data = model1[int'(a[9:0])];
                    if (k == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
            end
            step();
        end
        ms_valid[k] = 1'b0;
        ms_write[k] = 1'b0;
    endtask

    task automatic op(input int k, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [7:0] id, input int max_wait);
        bit ok;
        issue(k, wr, a, d, id, max_wait, ok);
        chk($sformatf("accept_%0d_%h", k, a), 40'(ok), 40'd1);
    endtask

    task automatic drain(input int k);
        for (int i = 0; i < 20 && qsize(k) != 0; i++) step();
        chk($sformatf("drain_%0d", k), 40'(qsize(k)), 40'd0);
    endtask

    // Response scoreboard and idle-output check.
    task automatic mon(input int k);
        exp_t e;
        if (sm_valid[k] === 1'b1 && sm_taken[k] === 1'b1) begin
            chk($sformatf("resp_expected_%0d", k), 40'(qsize(k) != 0), 40'd1);
            if (qsize(k) != 0) begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("resp_%0d", k), {sm_data[k], sm_id[k]}, {e.data, e.id});
            end
        end else if (sm_valid[k] === 1'b0) begin
            chk($sformatf("idle_zero_%0d", k), {sm_data[k], sm_id[k]}, 40'h0);
        end
    endtask

    always @(negedge clock) begin
        if (reset === 1'b0) begin
            mon(0);
            mon(1);
        end
    end

    initial begin
        bit ok;
        reset    = 1'b1;
        ms_valid = '0;
        ms_write = '0;
        ms_addr  = '0;
        ms_data  = '0;
        ms_id    = '0;
        sm_taken = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state, then ready on the following cycle.
        @(negedge clock);
        chk("rst_taken", 40'(ms_taken), 40'd0);
        chk("rst_valid", 40'(sm_valid), 40'd0);
        chk("rst_data_id_a", {sm_data[0], sm_id[0]}, 40'h0);
        step();
        @(negedge clock);
        chk("first_taken", 40'(ms_taken), 40'd3);
        step();

        // Write then read back with latency C+2.
        sm_taken = 2'b11;
        op(0, 1'b1, 32'd5, 32'h1234_5678, 8'h00, 1);
        op(0, 1'b0, 32'd5, 32'h0, 8'h3A, 1);
        @(negedge clock);
        chk("lat_c1_idle", 40'(sm_valid[0]), 40'd0);
        step();
        @(negedge clock);
        chk("lat_c2_valid", 40'(sm_valid[0]), 40'd1);
        chk("lat_c2_data", {sm_data[0], sm_id[0]}, {32'h1234_5678, 8'h3A});
        step();

        // Back-to-back reads at full rate.
        for (int i = 1; i <= 4; i++) op(0, 1'b1, 32'(i), 32'h1111_0000 + 32'(i), 8'h0, 1);
        for (int i = 1; i <= 3; i++) op(0, 1'b0, 32'(i), 32'h0, 8'(i), 1);
        @(negedge clock);
        chk("b2b_c3", {31'h0, sm_valid[0], sm_id[0]}, {31'h0, 1'b1, 8'd2});
        step();
        @(negedge clock);
        chk("b2b_c4", {31'h0, sm_valid[0], sm_id[0]}, {31'h0, 1'b1, 8'd3});
        step();
        @(negedge clock);
        chk("b2b_c5_idle", 40'(sm_valid[0]), 40'd0);
        step();

        // Backpressure: only two reads get in while smTaken is low.
        sm_taken[0] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            issue(0, 1'b0, 32'(i), 32'h0, 8'(8'h40 + i), 1, ok);
            chk($sformatf("bp_accept_%0d", i), 40'(ok), (i <= 2) ? 40'd1 : 40'd0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("bp_taken_low", 40'(ms_taken[0]), 40'd0);
            chk("bp_hold", {31'h0, sm_valid[0], sm_data[0], sm_id[0]},
                {31'h0, 1'b1, 32'h1111_0001, 8'h41});
            step();
        end
        sm_taken[0] = 1'b1;
        step();
        step();
        @(negedge clock);
        chk("bp_drained", {38'h0, sm_valid[0], ms_taken[0]}, 40'd1);
        chk("bp_queue_empty", 40'(qsize(0)), 40'd0);
        step();

        // Interleaving, aliasing out-of-range accesses, randomized mix.
        op(0, 1'b1, 32'd9, 32'hA5A5_5A5A, 8'h0, 1);
        op(0, 1'b0, 32'd9, 32'h0, 8'h50, 1);
        op(0, 1'b1, 32'd10, 32'h0F0F_1234, 8'h0, 1);
        op(0, 1'b0, 32'd10, 32'h0, 8'h51, 1);
        op(0, 1'b1, 32'h405, 32'hDEAD_BEEF, 8'h0, 1);
        op(0, 1'b0, 32'd5, 32'h0, 8'h52, 4);
        op(0, 1'b0, 32'h405, 32'h0, 8'h55, 4);
        for (int i = 0; i < 16; i++) op(0, 1'b1, 32'(i), $urandom, 8'h0, 4);
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 32'h0001_0000 : 32'h0);
            op(0, 1'($urandom_range(0, 1)), a, $urandom, 8'($urandom), 8);
        end
        drain(0);

        // Instance B: BASE=0x400.
        op(1, 1'b0, 32'h10, 32'h0, 8'h07, 1);
        step();
        @(negedge clock);
        chk("b_oor_read", {31'h0, sm_valid[1], sm_data[1], sm_id[1]}, {31'h0, 1'b1, 32'h0, 8'h07});
        step();
        op(1, 1'b1, 32'h400, 32'hCAFE_F00D, 8'h0, 4);
        op(1, 1'b1, 32'h410, 32'h0BAD_F00D, 8'h0, 4);
        op(1, 1'b1, 32'h10, 32'hFFFF_FFFF, 8'h0, 4);
        op(1, 1'b0, 32'h400, 32'h0, 8'h08, 4);
        op(1, 1'b0, 32'h410, 32'h0, 8'h09, 4);
        drain(1);

        // Reset with two reads queued: nothing comes out afterwards.
        sm_taken[0] = 1'b0;
        op(0, 1'b1, 32'd5, 32'h1234_5678, 8'h0, 4);
        op(0, 1'b0, 32'd5, 32'h0, 8'h71, 4);
        op(0, 1'b0, 32'd9, 32'h0, 8'h72, 4);
        reset = 1'b1;
        q0.delete();
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_state", {30'h0, ms_taken[0], sm_valid[0], sm_id[0]}, 40'h0);
        chk("mid_rst_data", 40'(sm_data[0]), 40'h0);
        step();
        sm_taken[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("no_stale_resp", 40'(sm_valid[0]), 40'd0);
            step();
        end
        op(0, 1'b0, 32'd5, 32'h0, 8'h73, 4);
        drain(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
